booth_ctrl: RTL and testbench

- FSM that sequences the 8-bit radix-2 Booth multiplier datapath from a start/done handshake.
- Per multiplication it:
  - loads A and {B,0}, clears the product register and presets the iteration count to 8;
  - runs 8 evaluate/shift iterations, selecting add or subtract from q_0_1;
  - stops when count_cp_zero is set and commits the product to the result register.
- It also supplies a clear command and a watchdog that flags datapath/controller count disagreement.

---
 rtl/booth_pkg.sv | 27 ++
 rtl/booth_ctrl_wdog.sv | 59 +++++
 rtl/booth_ctrl.sv | 161 ++++++++++++++++
 tb/tb_booth_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-2 Booth multiplier controller.
//   state_t      : controller state encoding (3-bit, binary)
//   Q_ADD/Q_SUB  : reg_uzunB[1:0] codes that request an add / a subtract
//   ITER_DEFAULT : evaluate/shift iterations per multiplication; must match
//                  the count value the datapath presets on set_count
// -----------------------------------------------------------------------------
package booth_pkg;

    localparam int ITER_DEFAULT       = 8;
    localparam int WDOG_SLACK_DEFAULT = 2;

    localparam logic [1:0] Q_ADD = 2'b01;
    localparam logic [1:0] Q_SUB = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LOAD  = 3'd2,
        EVAL  = 3'd3,
        SHIFT = 3'd4,
        WRITE = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/booth_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// booth_ctrl_wdog
// Counts EVAL visits of the Booth controller and raises a sticky error when
// the datapath count fails to reach zero within ITER + WDOG_SLACK visits.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_clr         : accepted start; clears the visit counter and the error
//   i_eval        : controller is in EVAL this cycle
//   i_count_zero  : datapath count == 0
//   o_trip        : combinational; abort the loop this cycle
//   o_err         : sticky error flag
// -----------------------------------------------------------------------------
module booth_ctrl_wdog #(
    parameter int ITER       = 8,
    parameter int WDOG_SLACK = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_eval,
    input  logic i_count_zero,
    output logic o_trip,
    output logic o_err
);

    localparam int LIMIT = ITER + WDOG_SLACK;
    // One spare bit above what LIMIT+1 needs so saturation never masks a trip.
    localparam int CNT_W = $clog2(LIMIT + 2) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_iter;
    logic [CNT_W-1:0] w_visit;
    logic             r_err;

    // Ordinal of the current EVAL visit (1 on the first visit), saturating.
    assign w_visit = (r_iter == CNT_MAX) ? CNT_MAX : r_iter + CNT_W'(1);

    assign o_trip = i_eval && !i_count_zero && (w_visit > LIMIT_C);
    assign o_err  = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter <= '0;
            r_err  <= 1'b0;
        end else if (i_clr) begin
            r_iter <= '0;
            r_err  <= 1'b0;
        end else begin
            if (i_eval) begin
                r_iter <= w_visit;
            end
            if (o_trip) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_ctrl.sv
// -----------------------------------------------------------------------------
// booth_ctrl
// Sequencer for an 8-bit radix-2 Booth multiplier datapath.
// A start in IDLE loads A and {B,0}, clears the product and presets the
// datapath count, runs ITER evaluate/shift iterations (add/subtract chosen
// from q_0_1), then commits the product to the result register and pulses
// done. A clear_req in IDLE clears A, B, product and result for one cycle.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, clear_req         : requests, sampled in IDLE only (start wins)
//   q_0_1, count_cp_zero     : status from the datapath
//   Awrite .. B_clr          : datapath controls (combinational state decode)
//   busy                     : high in every state except IDLE
//   done                     : one-cycle pulse once result is updated
//   err                      : sticky watchdog error
// -----------------------------------------------------------------------------
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int ITER       = ITER_DEFAULT,
    parameter int WDOG_SLACK = WDOG_SLACK_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear_req,
    input  logic [1:0] q_0_1,
    input  logic       count_cp_zero,
    output logic       Awrite,
    output logic       Bwrite,
    output logic       reg_uzunB_ld,
    output logic       Add_Sub,
    output logic       shift_carpim,
    output logic       carpim_ld,
    output logic       carpim_clr,
    output logic       set_count,
    output logic       ld_count,
    output logic       result_ld,
    output logic       result_clr,
    output logic       A_clr,
    output logic       B_clr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t r_state;
    state_t w_state_next;
    logic   w_start_acc;
    logic   w_eval;
    logic   w_trip;

    assign w_eval = (r_state == EVAL);

    booth_ctrl_wdog #(
        .ITER       (ITER),
        .WDOG_SLACK (WDOG_SLACK)
    ) u_wdog (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_start_acc),
        .i_eval       (w_eval),
        .i_count_zero (count_cp_zero),
        .o_trip       (w_trip),
        .o_err        (err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        Awrite       = 1'b0;
        Bwrite       = 1'b0;
        reg_uzunB_ld = 1'b0;
        Add_Sub      = 1'b0;
        shift_carpim = 1'b0;
        carpim_ld    = 1'b0;
        carpim_clr   = 1'b0;
        set_count    = 1'b0;
        ld_count     = 1'b0;
        result_ld    = 1'b0;
        result_clr   = 1'b0;
        A_clr        = 1'b0;
        B_clr        = 1'b0;
        busy         = (r_state != IDLE);
        done         = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = LOAD;
                end else if (clear_req) begin
                    w_state_next = CLR;
                end
            end
            CLR: begin
                result_clr   = 1'b1;
                A_clr        = 1'b1;
                B_clr        = 1'b1;
                carpim_clr   = 1'b1;
                w_state_next = IDLE;
            end
            LOAD: begin
                Awrite       = 1'b1;
                Bwrite       = 1'b1;
                carpim_clr   = 1'b1;
                set_count    = 1'b1;
                ld_count     = 1'b1;
                w_state_next = EVAL;
            end
            EVAL: begin
                // A tripped watchdog leaves the loop without touching the
                // product, exactly like a normal count-zero exit.
                if (count_cp_zero || w_trip) begin
                    w_state_next = WRITE;
                end else begin
                    w_state_next = SHIFT;
                    case (q_0_1)
                        Q_ADD: begin
                            carpim_ld = 1'b1;
                            Add_Sub   = 1'b0;
                        end
                        Q_SUB: begin
                            carpim_ld = 1'b1;
                            Add_Sub   = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            SHIFT: begin
                shift_carpim = 1'b1;
                carpim_ld    = 1'b1;
                reg_uzunB_ld = 1'b1;
                ld_count     = 1'b1;
                w_state_next = EVAL;
            end
            WRITE: begin
                result_ld    = 1'b1;
                w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// -----------------------------------------------------------------------------
// tb_booth_ctrl
// booth_ctrl wired to a behavioural 8-bit Booth datapath. Stimulus pushes the
// expected outcome of each multiplication into a queue; a monitor pops and
// compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_booth_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       clear_req;
    logic [1:0] q_0_1;
    logic       count_cp_zero;
    logic       Awrite, Bwrite, reg_uzunB_ld, Add_Sub, shift_carpim, carpim_ld;
    logic       carpim_clr, set_count, ld_count, result_ld, result_clr, A_clr, B_clr;
    logic       busy, done, err;

    booth_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .clear_req     (clear_req),
        .q_0_1         (q_0_1),
        .count_cp_zero (count_cp_zero),
        .Awrite        (Awrite),
        .Bwrite        (Bwrite),
        .reg_uzunB_ld  (reg_uzunB_ld),
        .Add_Sub       (Add_Sub),
        .shift_carpim  (shift_carpim),
        .carpim_ld     (carpim_ld),
        .carpim_clr    (carpim_clr),
        .set_count     (set_count),
        .ld_count      (ld_count),
        .result_ld     (result_ld),
        .result_clr    (result_clr),
        .A_clr         (A_clr),
        .B_clr         (B_clr),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural datapath ----------------
    logic [7:0]  op_a, op_b;
    logic [7:0]  dp_a;
    logic [8:0]  dp_uzunb;
    logic [15:0] dp_carpim, dp_result;
    logic [3:0]  dp_count;
    logic        force_nz;

    always @(posedge clk) begin
        if (A_clr)       dp_a <= 8'h00;
        else if (Awrite) dp_a <= op_a;

        if (B_clr)             dp_uzunb <= 9'h000;
        else if (Bwrite)       dp_uzunb <= {op_b, 1'b0};
        else if (reg_uzunB_ld) dp_uzunb <= {dp_uzunb[8], dp_uzunb[8:1]};

        if (carpim_clr) dp_carpim <= 16'h0000;
        else if (carpim_ld) begin
            if (shift_carpim) dp_carpim <= {dp_carpim[15], dp_carpim[15:1]};
            else if (Add_Sub) dp_carpim <= dp_carpim - {dp_a, 8'h00};
            else              dp_carpim <= dp_carpim + {dp_a, 8'h00};
        end

        if (ld_count) dp_count <= set_count ? 4'd8 : dp_count - 4'd1;

        if (result_clr)     dp_result <= 16'h0000;
        else if (result_ld) dp_result <= dp_carpim;
    end

    assign q_0_1         = dp_uzunb[1:0];
    assign count_cp_zero = (dp_count == 4'd0) && !force_nz;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] res;
        logic        e;
        int          lat;
        int          shifts;
        int          adds;
        int          subs;
        int          sub_pos;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc_prev = 0;
    int done_cyc_last = 0;
    int rclr_cnt = 0;
    int clr_all_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] res, input logic e, input int lat,
                            input int shifts, input int adds, input int subs, input int sub_pos);
        exp_t x;
        x.res = res; x.e = e; x.lat = lat; x.shifts = shifts;
        x.adds = adds; x.subs = subs; x.sub_pos = sub_pos;
        exp_q.push_back(x);
    endtask

    // Monitor: per-operation activity counters, compared at each done pulse.
    initial begin : monitor
        int bcnt, shf, shf_b, adds, subs, sub_pos;
        exp_t x;
        bcnt = 0; shf = 0; shf_b = 0; adds = 0; subs = 0; sub_pos = -1;
        forever begin
            @(negedge clk);
            if (result_clr) rclr_cnt++;
            if (result_clr && A_clr && B_clr && carpim_clr) clr_all_cnt++;
            if (rst || !busy) begin
                bcnt = 0; shf = 0; shf_b = 0; adds = 0; subs = 0; sub_pos = -1;
            end else begin
                bcnt++;
                if (shift_carpim) begin
                    shf++;
                    if (reg_uzunB_ld && carpim_ld) shf_b++;
                end
                if (carpim_ld && !shift_carpim) begin
                    if (Add_Sub) begin
                        subs++;
                        sub_pos = shf;
                    end else begin
                        adds++;
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc_prev = done_cyc_last;
                    done_cyc_last = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        chk("result", int'(dp_result), int'(x.res));
                        chk("err_at_done", int'(err), int'(x.e));
                        chk("busy_cycles", bcnt, x.lat);
                        chk("shift_visits", shf, x.shifts);
                        chk("shift_with_uzunB_ld", shf_b, x.shifts);
                        chk("add_loads", adds, x.adds);
                        chk("sub_loads", subs, x.subs);
                        if (x.sub_pos >= 0) chk("sub_position", sub_pos, x.sub_pos);
                        $display("op done: result=0x%04h err=%0d busy_cycles=%0d shifts=%0d adds=%0d subs=%0d",
                                 dp_result, err, bcnt, shf, adds, subs);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] res,
                         input logic e, input int lat, input int shifts, input int adds,
                         input int subs, input int sub_pos, input logic with_clr);
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1; clear_req = with_clr;
        push_exp(res, e, lat, shifts, adds, subs, sub_pos);
        @(negedge clk);
        start = 1'b0; clear_req = 1'b0;
        chk("err_clear_on_start", int'(err), 0);
        chk("busy_cycle1", int'(busy), 1);
    endtask

    task automatic wait_dones(input int n);
        int k;
        k = 0;
        while (done_cnt < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("done_count", done_cnt, n);
        @(negedge clk);
    endtask

    function automatic logic [15:0] all_outs();
        return {Awrite, Bwrite, reg_uzunB_ld, Add_Sub, shift_carpim, carpim_ld, carpim_clr,
                set_count, ld_count, result_ld, result_clr, A_clr, B_clr, busy, done, err};
    endfunction

    initial begin : global_timeout
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        int base;
        int base_all;
        int base_done;
        rst = 1'b1; start = 1'b0; clear_req = 1'b0; force_nz = 1'b0;
        op_a = 8'h00; op_b = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(all_outs()), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", int'(all_outs()), 0);

        // 3 * 5
        issue(8'd3, 8'd5, 16'h000F, 1'b0, 20, 8, 2, 2, -1, 1'b0);
        wait_dones(1);

        // 7 * -3, with clear_req held while busy (must be ignored)
        base = rclr_cnt;
        issue(8'd7, 8'hFD, 16'hFFEB, 1'b0, 20, 8, 1, 2, -1, 1'b0);
        clear_req = 1'b1;
        repeat (10) @(negedge clk);
        clear_req = 1'b0;
        wait_dones(2);
        chk("clear_ignored_when_busy", rclr_cnt - base, 0);

        // 127 * -128: one subtract, in the 8th EVAL
        issue(8'd127, 8'h80, 16'hC080, 1'b0, 20, 8, 0, 1, 7, 1'b0);
        wait_dones(3);

        // start and clear_req together: start wins
        base = rclr_cnt;
        issue(8'd5, 8'd6, 16'h001E, 1'b0, 20, 8, 1, 1, -1, 1'b1);
        wait_dones(4);
        chk("start_beats_clear", rclr_cnt - base, 0);

        // start held high: no queuing, back-to-back accept after DONE
        @(negedge clk);
        op_a = 8'hFC; op_b = 8'd9; start = 1'b1;
        push_exp(16'hFFDC, 1'b0, 20, 8, 2, 2, -1);
        push_exp(16'hFFDC, 1'b0, 20, 8, 2, 2, -1);
        wait_dones(5);
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_dones(6);
        chk("back_to_back_done_gap", done_cyc_last - done_cyc_prev, 21);
        repeat (30) @(negedge clk);
        chk("no_extra_operation", done_cnt, 6);

        // asynchronous reset in cycle 10 of an operation
        @(negedge clk);
        op_a = 8'd9; op_b = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_reset", int'(busy), 1);
        #2 rst = 1'b1;
        #1 chk("outputs_on_async_reset", int'(all_outs()), 0);
        @(negedge clk);
        rst = 1'b0;
        issue(8'd2, 8'd2, 16'h0004, 1'b0, 20, 8, 1, 1, -1, 1'b0);
        wait_dones(7);

        // watchdog: count never reaches zero
        force_nz = 1'b1;
        issue(8'd5, 8'd0, 16'h0000, 1'b1, 24, 10, 0, 0, -1, 1'b0);
        wait_dones(8);
        repeat (2) @(negedge clk);
        chk("err_sticky_in_idle", int'(err), 1);
        force_nz = 1'b0;
        issue(8'd3, 8'd5, 16'h000F, 1'b0, 20, 8, 2, 2, -1, 1'b0);
        wait_dones(9);

        // clear request in IDLE
        base      = rclr_cnt;
        base_all  = clr_all_cnt;
        base_done = done_cnt;
        chk("result_before_clear", int'(dp_result), 16'h000F);
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("clear_result_clr_cycles", rclr_cnt - base, 1);
        chk("clear_all_four_cycles", clr_all_cnt - base_all, 1);
        chk("result_after_clear", int'(dp_result), 0);
        chk("clear_no_done", done_cnt, base_done);
        $display("clear op: result=0x%04h", dp_result);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
